// File: rtl/ysyx_store_queue.sv
// ysyx_store_queue
// Store queue sitting between LSU commit and the bus store channel. Committed
// stores are buffered in FIFO order and drained one at a time over the
// awaddr/wdata handshake; a bus_wready pulse completes the head store. The
// queue also reports whether a pending store touches the same word as the
// load currently in the LSU so that load can be stalled.

module ysyx_store_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            sq_valid,
   input  logic [XLEN-1:0] sq_addr,
   input  logic [XLEN-1:0] sq_data,
   input  logic [7:0]      sq_wstrb,
   output logic            out_sq_ready,
   input  logic [XLEN-1:0] ld_addr,
   output logic            out_ld_hit,
   output logic            out_empty,
   output logic [XLEN-1:0] out_lsu_awaddr,
   output logic            out_lsu_awvalid,
   output logic [XLEN-1:0] out_lsu_wdata,
   output logic [7:0]      out_lsu_wstrb,
   output logic            out_lsu_wvalid,
   input  logic            bus_wready
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   // Drain-side states: idle, presenting the head store, and the mandatory
   // one-cycle idle gap after every completed store.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [XLEN-1:0] addr_q [DEPTH];
   logic [XLEN-1:0] data_q [DEPTH];
   logic [7:0]      strb_q [DEPTH];
   logic [DEPTH-1:0] valid_q;

   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          ready_q;

   logic enq;
   logic pop;
   logic send;
   logic hit;

   // Only the word part of the load address participates in the hazard check.
   logic unused_ld_low_bits;
   assign unused_ld_low_bits = ^ld_addr[1:0];

   assign enq  = sq_valid && ready_q;
   assign pop  = (state_q == S_SEND) && bus_wready;
   assign send = (state_q == S_SEND);

   // Occupancy after this cycle; a same-cycle enqueue and pop cancel out.
   always_comb begin
      count_d = count_q;
      case ({enq, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointers, occupancy and the registered ready flag. Ready is derived from
   // the next occupancy so it never anticipates a pop happening in the same
   // cycle as the enqueue it gates, and it stays low while in reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (enq) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         count_q <= count_d;
         ready_q <= (count_d < FULL_COUNT);
      end
   end

   // Entry storage and per-entry valid bits. A popped entry is retired before
   // a new one is written so the slot bookkeeping stays consistent even if
   // the two ever target the same index.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            strb_q[i] <= '0;
         end
      end else begin
         if (pop) begin
            valid_q[rd_ptr_q] <= 1'b0;
         end
         if (enq) begin
            valid_q[wr_ptr_q] <= 1'b1;
            addr_q[wr_ptr_q]  <= sq_addr;
            data_q[wr_ptr_q]  <= sq_data;
            strb_q[wr_ptr_q]  <= sq_wstrb;
         end
      end
   end

   // Drain state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Drain next-state logic. The gap state looks at the occupancy after the
   // pop, so a queue refilled during the send goes straight back to sending.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (bus_wready) begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (count_q != '0) begin
               state_d = S_SEND;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Drain outputs: the head entry is presented only while sending and the
   // bus sees zeros otherwise, including during reset.
   always_comb begin
      out_lsu_awvalid = 1'b0;
      out_lsu_wvalid  = 1'b0;
      out_lsu_awaddr  = '0;
      out_lsu_wdata   = '0;
      out_lsu_wstrb   = '0;
      if (send) begin
         out_lsu_awvalid = 1'b1;
         out_lsu_wvalid  = 1'b1;
         out_lsu_awaddr  = addr_q[rd_ptr_q];
         out_lsu_wdata   = data_q[rd_ptr_q];
         out_lsu_wstrb   = strb_q[rd_ptr_q];
      end
   end

   // Load hazard: any valid entry, including the one in flight, whose word
   // address matches the load's word address.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i][XLEN-1:2] == ld_addr[XLEN-1:2])) begin
            hit = 1'b1;
         end
      end
   end

   assign out_ld_hit   = hit;
   assign out_sq_ready = ready_q;
   assign out_empty    = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_ysyx_store_queue.sv
// Testbench for ysyx_store_queue: scenario tasks drive stores and bus
// responses; expected head stores come from a scoreboard queue filled at
// enqueue time and popped when the bench completes a store on the bus.

module tb_ysyx_store_queue;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        sq_valid = 1'b0;
   logic [31:0] sq_addr = '0;
   logic [31:0] sq_data = '0;
   logic [7:0]  sq_wstrb = '0;
   logic        out_sq_ready;
   logic [31:0] ld_addr = '0;
   logic        out_ld_hit;
   logic        out_empty;
   logic [31:0] out_lsu_awaddr;
   logic        out_lsu_awvalid;
   logic [31:0] out_lsu_wdata;
   logic [7:0]  out_lsu_wstrb;
   logic        out_lsu_wvalid;
   logic        bus_wready = 1'b0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [7:0]  s;
   } st_t;

   st_t sb[$];
   int  mcount = 0;
   int  total = 0;
   int  bad = 0;

   ysyx_store_queue #(.XLEN(32), .DEPTH(4)) dut (
      .clock           (clock),
      .reset           (reset),
      .sq_valid        (sq_valid),
      .sq_addr         (sq_addr),
      .sq_data         (sq_data),
      .sq_wstrb        (sq_wstrb),
      .out_sq_ready    (out_sq_ready),
      .ld_addr         (ld_addr),
      .out_ld_hit      (out_ld_hit),
      .out_empty       (out_empty),
      .out_lsu_awaddr  (out_lsu_awaddr),
      .out_lsu_awvalid (out_lsu_awvalid),
      .out_lsu_wdata   (out_lsu_wdata),
      .out_lsu_wstrb   (out_lsu_wstrb),
      .out_lsu_wvalid  (out_lsu_wvalid),
      .bus_wready      (bus_wready)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   // One-cycle enqueue; the model records the store if the queue has room.
   task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
      st_t e;
      e.a = a; e.d = d; e.s = s;
      sq_valid = 1'b1; sq_addr = a; sq_data = d; sq_wstrb = s;
      if (mcount < 4) begin
         sb.push_back(e);
         mcount++;
      end
      step();
      sq_valid = 1'b0;
   endtask

   task automatic wait_send(output bit ok);
      int n = 0;
      while (!out_lsu_awvalid && n < 20) begin
         step();
         n++;
      end
      ok = out_lsu_awvalid;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (5) step();
      total++; if (out_lsu_awvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_awvalid got=%0b want=0", out_lsu_awvalid); end
      total++; if (out_lsu_wvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_wvalid got=%0b want=0", out_lsu_wvalid); end
      total++; if (out_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%0b want=1", out_empty); end
      total++; if (out_sq_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%0b want=0", out_sq_ready); end
      total++; if (out_ld_hit !== 1'b0) begin bad++; $display("[TB] FAIL reset_hit got=%0b want=0", out_ld_hit); end
      total++; if (out_lsu_awaddr !== 32'h0) begin bad++; $display("[TB] FAIL reset_awaddr got=%h want=0", out_lsu_awaddr); end
      reset = 1'b1;
      step();
      total++; if (out_sq_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_ready got=%0b want=1", out_sq_ready); end
      total++; if (out_empty !== 1'b1) begin bad++; $display("[TB] FAIL release_empty got=%0b want=1", out_empty); end
   endtask

   task automatic test_single();
      st_t e;
      enq(32'h8000_0004, 32'hDEAD_BEEF, 8'hf);
      total++; if (out_lsu_awvalid !== 1'b0) begin bad++; $display("[TB] FAIL single_t1_awvalid got=%0b want=0", out_lsu_awvalid); end
      total++; if (out_empty !== 1'b0) begin bad++; $display("[TB] FAIL single_t1_empty got=%0b want=0", out_empty); end
      step();
      total++; if (out_lsu_awvalid !== 1'b1 || out_lsu_wvalid !== 1'b1) begin bad++; $display("[TB] FAIL single_t2_valid got=%0b%0b want=11", out_lsu_awvalid, out_lsu_wvalid); end
      total++; if (out_lsu_awaddr !== sb[0].a) begin bad++; $display("[TB] FAIL single_awaddr got=%h want=%h", out_lsu_awaddr, sb[0].a); end
      total++; if (out_lsu_wdata !== sb[0].d) begin bad++; $display("[TB] FAIL single_wdata got=%h want=%h", out_lsu_wdata, sb[0].d); end
      total++; if (out_lsu_wstrb !== sb[0].s) begin bad++; $display("[TB] FAIL single_wstrb got=%h want=%h", out_lsu_wstrb, sb[0].s); end
      step(); step(); step();
      total++; if (out_lsu_awvalid !== 1'b1 || out_lsu_awaddr !== sb[0].a) begin bad++; $display("[TB] FAIL single_t5_hold got=%0b/%h want=1/%h", out_lsu_awvalid, out_lsu_awaddr, sb[0].a); end
      bus_wready = 1'b1;
      step();
      bus_wready = 1'b0;
      e = sb.pop_front();
      mcount--;
      total++; if (out_lsu_awvalid !== 1'b0) begin bad++; $display("[TB] FAIL single_t6_awvalid got=%0b want=0", out_lsu_awvalid); end
      total++; if (out_empty !== 1'b0) begin bad++; $display("[TB] FAIL single_t6_empty got=%0b want=0", out_empty); end
      step();
      total++; if (out_empty !== 1'b1) begin bad++; $display("[TB] FAIL single_t7_empty got=%0b want=1 (last %h)", out_empty, e.a); end
   endtask

   task automatic test_fill();
      logic [7:0] strbs [4] = '{8'h1, 8'h3, 8'hf, 8'hf};
      st_t e;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         enq(32'h8000_1000 + 32'(i * 16), $urandom, strbs[i]);
      end
      total++; if (out_sq_ready !== (mcount < 4)) begin bad++; $display("[TB] FAIL fill_ready got=%0b want=%0b", out_sq_ready, (mcount < 4)); end
      sq_valid = 1'b1; sq_addr = 32'h8000_2000; sq_data = 32'h5555_AAAA; sq_wstrb = 8'hf;
      ld_addr = 32'h8000_2000;
      for (int i = 0; i < 2; i++) begin
         step();
         total++; if (out_sq_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_held_ready got=%0b want=0", out_sq_ready); end
      end
      total++; if (out_ld_hit !== 1'b0) begin bad++; $display("[TB] FAIL fill_fifth_not_stored got=%0b want=0", out_ld_hit); end
      sq_valid = 1'b0;
      while (sb.size() > 0) begin
         wait_send(ok);
         total++; if (!ok) begin bad++; $display("[TB] FAIL fill_timeout got=0 want=1"); break; end
         total++; if (out_lsu_awaddr !== sb[0].a || out_lsu_wdata !== sb[0].d || out_lsu_wstrb !== sb[0].s) begin
            bad++; $display("[TB] FAIL fill_order got=%h/%h/%h want=%h/%h/%h", out_lsu_awaddr, out_lsu_wdata, out_lsu_wstrb, sb[0].a, sb[0].d, sb[0].s);
         end
         bus_wready = 1'b1;
         step();
         bus_wready = 1'b0;
         e = sb.pop_front();
         mcount--;
         total++; if (out_lsu_awvalid !== 1'b0) begin bad++; $display("[TB] FAIL fill_gap got=%0b want=0", out_lsu_awvalid); end
         step();
         total++; if (out_lsu_awvalid !== (sb.size() > 0)) begin bad++; $display("[TB] FAIL fill_after_gap got=%0b want=%0b", out_lsu_awvalid, (sb.size() > 0)); end
      end
      total++; if (out_empty !== 1'b1) begin bad++; $display("[TB] FAIL fill_empty got=%0b want=1", out_empty); end
   endtask

   task automatic test_simultaneous();
      st_t e;
      st_t c;
      bit ok;
      enq(32'h8000_3000, 32'h1111_0000, 8'hf);
      enq(32'h8000_3004, 32'h2222_0000, 8'h3);
      wait_send(ok);
      total++; if (!ok || out_lsu_awaddr !== sb[0].a) begin bad++; $display("[TB] FAIL simul_head got=%h want=%h", out_lsu_awaddr, sb[0].a); end
      total++; if (out_sq_ready !== 1'b1) begin bad++; $display("[TB] FAIL simul_ready_pre got=%0b want=1", out_sq_ready); end
      c.a = 32'h8000_3008; c.d = 32'h3333_0000; c.s = 8'h1;
      bus_wready = 1'b1;
      sq_valid = 1'b1; sq_addr = c.a; sq_data = c.d; sq_wstrb = c.s;
      sb.push_back(c);
      e = sb.pop_front();
      step();
      bus_wready = 1'b0;
      sq_valid = 1'b0;
      total++; if (out_lsu_awvalid !== 1'b0) begin bad++; $display("[TB] FAIL simul_gap got=%0b want=0", out_lsu_awvalid); end
      total++; if (out_sq_ready !== (mcount < 4)) begin bad++; $display("[TB] FAIL simul_ready_post got=%0b want=%0b", out_sq_ready, (mcount < 4)); end
      enq(32'h8000_300C, 32'h4444_0000, 8'hf);
      total++; if (out_lsu_awvalid !== 1'b1 || out_lsu_awaddr !== sb[0].a) begin bad++; $display("[TB] FAIL simul_second got=%0b/%h want=1/%h", out_lsu_awvalid, out_lsu_awaddr, sb[0].a); end
      while (sb.size() > 0) begin
         wait_send(ok);
         total++; if (!ok) begin bad++; $display("[TB] FAIL simul_timeout got=0 want=1"); break; end
         total++; if (out_lsu_awaddr !== sb[0].a || out_lsu_wdata !== sb[0].d || out_lsu_wstrb !== sb[0].s) begin
            bad++; $display("[TB] FAIL simul_order got=%h/%h/%h want=%h/%h/%h", out_lsu_awaddr, out_lsu_wdata, out_lsu_wstrb, sb[0].a, sb[0].d, sb[0].s);
         end
         bus_wready = 1'b1;
         step();
         bus_wready = 1'b0;
         e = sb.pop_front();
         mcount--;
         step();
      end
      total++; if (out_empty !== 1'b1) begin bad++; $display("[TB] FAIL simul_empty got=%0b want=1", out_empty); end
   endtask

   task automatic test_load_hazard();
      st_t e;
      bit ok;
      ld_addr = 32'h8000_0100;
      enq(32'h8000_0102, 32'h0000_00AB, 8'h1);
      #1;
      total++; if (out_ld_hit !== 1'b1) begin bad++; $display("[TB] FAIL hazard_same_word got=%0b want=1", out_ld_hit); end
      ld_addr = 32'h8000_0104; #1;
      total++; if (out_ld_hit !== 1'b0) begin bad++; $display("[TB] FAIL hazard_next_word got=%0b want=0", out_ld_hit); end
      ld_addr = 32'h8000_0103; #1;
      total++; if (out_ld_hit !== 1'b1) begin bad++; $display("[TB] FAIL hazard_byte3 got=%0b want=1", out_ld_hit); end
      ld_addr = 32'h8000_0100;
      wait_send(ok);
      total++; if (!ok || out_ld_hit !== 1'b1) begin bad++; $display("[TB] FAIL hazard_inflight got=%0b want=1", out_ld_hit); end
      total++; if (out_lsu_awaddr !== sb[0].a || out_lsu_wdata !== sb[0].d) begin bad++; $display("[TB] FAIL hazard_store got=%h/%h want=%h/%h", out_lsu_awaddr, out_lsu_wdata, sb[0].a, sb[0].d); end
      bus_wready = 1'b1;
      step();
      bus_wready = 1'b0;
      e = sb.pop_front();
      mcount--;
      #1;
      total++; if (out_ld_hit !== 1'b0) begin bad++; $display("[TB] FAIL hazard_after_pop got=%0b want=0", out_ld_hit); end
      step();
   endtask

   task automatic test_reset_mid();
      bit ok;
      enq(32'h8000_4000, 32'hA000_0001, 8'hf);
      enq(32'h8000_4004, 32'hA000_0002, 8'hf);
      enq(32'h8000_4008, 32'hA000_0003, 8'hf);
      ld_addr = 32'h8000_4000;
      wait_send(ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL midreset_send got=0 want=1"); end
      #2;
      reset = 1'b0;
      #1;
      sb.delete();
      mcount = 0;
      total++; if (out_lsu_awvalid !== 1'b0 || out_lsu_wvalid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid got=%0b%0b want=00", out_lsu_awvalid, out_lsu_wvalid); end
      total++; if (out_empty !== 1'b1) begin bad++; $display("[TB] FAIL midreset_empty got=%0b want=1", out_empty); end
      total++; if (out_ld_hit !== 1'b0) begin bad++; $display("[TB] FAIL midreset_hit got=%0b want=0", out_ld_hit); end
      @(negedge clock);
      reset = 1'b1;
      step();
      total++; if (out_sq_ready !== 1'b1 || out_empty !== 1'b1) begin bad++; $display("[TB] FAIL midreset_release got=%0b%0b want=11", out_sq_ready, out_empty); end
      step(); step();
      total++; if (out_lsu_awvalid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_no_drain got=%0b want=0", out_lsu_awvalid); end
   endtask

   // Overall watchdog so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scenario sequence.
   initial begin
      test_reset();
      test_single();
      test_fill();
      test_simultaneous();
      test_load_hazard();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
